// File: rtl/alu_mc_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_mc_if
//  Description : Operand/result handshake bundle for the multi-cycle ALU.
//                master = execute-stage driver, slave = alu_mc.
//  Signals     : in_valid/in_ready + A/B/CTRL   operand channel
//                out_valid/out_ready + R/flags  result channel
//  Revision    : 1.0  initial release
// ============================================================================
interface alu_mc_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [2:0]       CTRL;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] R;
    logic             zero;
    logic             ovf;
    logic             carry;
    logic             branch;

    modport master (
        output in_valid, A, B, CTRL, out_ready,
        input  in_ready, out_valid, R, zero, ovf, carry, branch
    );

    modport slave (
        input  in_valid, A, B, CTRL, out_ready,
        output in_ready, out_valid, R, zero, ovf, carry, branch
    );
endinterface
`default_nettype wire

// File: rtl/alu_mc.sv
`default_nettype none
// ============================================================================
//  Module      : alu_mc
//  Description : Multi-cycle integer ALU for the execute stage.
//                Single-cycle ADD/SUB/XOR/BEQ/OR/AND/SLT, iterative
//                shift-add MUL taking WIDTH cycles. Registered result with
//                valid/ready backpressure on both sides.
//  Ports       : clk    - clock, rising edge
//                reset  - asynchronous reset, active low
//                bus    - alu_mc_if.slave (operand and result channels)
//  Parameters  : WIDTH  - operand/result width (>= 4)
//                CNT_W  - MUL iteration counter width, 2**CNT_W > WIDTH
//  Revision    : 1.0  initial release
// ============================================================================
module alu_mc #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic     clk,
    input  logic     reset,
    alu_mc_if.slave  bus
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_BEQ = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_AND = 3'b101;
    localparam logic [2:0] OP_SLT = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   r_q;
    logic               zero_q;
    logic               ovf_q;
    logic               carry_q;
    logic               branch_q;
    logic               out_valid_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               in_rdy;
    logic               accept;
    logic               pop;

    logic [WIDTH:0]     sum_d;
    logic [WIDTH-1:0]   diff_d;
    logic [WIDTH-1:0]   r_d;
    logic               ovf_d;
    logic               carry_d;
    logic               branch_d;
    logic [2*WIDTH-1:0] acc_d;

    // A new op may enter only when idle and the output slot is free or
    // being emptied this very edge, which gives 1 op/cycle streaming.
    assign in_rdy = (state_q == S_IDLE) && (!out_valid_q || bus.out_ready);
    assign accept = bus.in_valid && in_rdy;
    assign pop    = out_valid_q && bus.out_ready;

    assign sum_d  = {1'b0, bus.A} + {1'b0, bus.B};
    assign diff_d = bus.A - bus.B;

    // Accumulator value after the current MUL step, used both for the
    // state update and for the final result on the last iteration.
    assign acc_d  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    always_comb begin
        r_d      = '0;
        ovf_d    = 1'b0;
        carry_d  = 1'b0;
        branch_d = 1'b0;
        case (bus.CTRL)
            OP_ADD: begin
                r_d     = sum_d[WIDTH-1:0];
                carry_d = sum_d[WIDTH];
                ovf_d   = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) &&
                          (sum_d[WIDTH-1] != bus.A[WIDTH-1]);
            end
            OP_SUB: begin
                r_d     = diff_d;
                carry_d = (bus.A < bus.B);
                ovf_d   = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) &&
                          (diff_d[WIDTH-1] != bus.A[WIDTH-1]);
            end
            OP_XOR: r_d = bus.A ^ bus.B;
            OP_BEQ: begin
                // R carries the difference so that zero mirrors branch.
                r_d      = diff_d;
                branch_d = (bus.A == bus.B);
            end
            OP_OR:  r_d = bus.A | bus.B;
            OP_AND: r_d = bus.A & bus.B;
            OP_SLT: r_d = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
            default: r_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            r_q         <= '0;
            zero_q      <= 1'b1;
            ovf_q       <= 1'b0;
            carry_q     <= 1'b0;
            branch_q    <= 1'b0;
            out_valid_q <= 1'b0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        if (bus.CTRL == OP_MUL) begin
                            mcand_q     <= {{WIDTH{1'b0}}, bus.A};
                            mplier_q    <= bus.B;
                            acc_q       <= '0;
                            cnt_q       <= '0;
                            // Slot is free or being popped, so nothing is lost.
                            out_valid_q <= 1'b0;
                            state_q     <= S_MUL;
                        end else begin
                            r_q         <= r_d;
                            zero_q      <= (r_d == '0);
                            ovf_q       <= ovf_d;
                            carry_q     <= carry_d;
                            branch_q    <= branch_d;
                            out_valid_q <= 1'b1;
                        end
                    end else if (pop) begin
                        out_valid_q <= 1'b0;
                    end
                end
                S_MUL: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_ITER) begin
                        r_q         <= acc_d[WIDTH-1:0];
                        zero_q      <= (acc_d[WIDTH-1:0] == '0);
                        ovf_q       <= |acc_d[2*WIDTH-1:WIDTH];
                        carry_q     <= 1'b0;
                        branch_q    <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = out_valid_q;
    assign bus.R         = r_q;
    assign bus.zero      = zero_q;
    assign bus.ovf       = ovf_q;
    assign bus.carry     = carry_q;
    assign bus.branch    = branch_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_mc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_mc
//  Description : Scoreboard bench for alu_mc at WIDTH=32 and WIDTH=8.
//                Stimulus pushes expected results into per-DUT queues; a
//                monitor per DUT pops and compares on every result pop.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_mc;

    localparam logic [2:0] ADD = 3'b000;
    localparam logic [2:0] SUB = 3'b001;
    localparam logic [2:0] XOR = 3'b010;
    localparam logic [2:0] BEQ = 3'b011;
    localparam logic [2:0] OR  = 3'b100;
    localparam logic [2:0] AND = 3'b101;
    localparam logic [2:0] SLT = 3'b110;
    localparam logic [2:0] MUL = 3'b111;

    typedef struct packed {
        logic [31:0] r;
        logic        zero;
        logic        ovf;
        logic        carry;
        logic        branch;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    alu_mc_if #(.WIDTH(32)) b32 ();
    alu_mc_if #(.WIDTH(8))  b8  ();

    logic bp_en   = 1'b0;
    logic rdy_rnd = 1'b1;
    logic rdy32_m = 1'b1;
    logic rdy8_m  = 1'b1;
    assign b32.out_ready = bp_en ? rdy_rnd : rdy32_m;
    assign b8.out_ready  = bp_en ? rdy_rnd : rdy8_m;

    alu_mc #(.WIDTH(32), .CNT_W(6)) dut32 (.clk(clk), .reset(reset), .bus(b32.slave));
    alu_mc #(.WIDTH(8),  .CNT_W(4)) dut8  (.clk(clk), .reset(reset), .bus(b8.slave));

    exp_t q32[$];
    exp_t q8[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] r, input logic z, input logic o,
                                input logic c, input logic b);
        exp_t e;
        e.r = r; e.zero = z; e.ovf = o; e.carry = c; e.branch = b;
        return e;
    endfunction

    // Reference model: plain integer arithmetic on the w-bit values.
    function automatic exp_t model(input int w, input logic [2:0] op,
                                   input logic [31:0] a, input logic [31:0] b);
        longint unsigned mask, ua, ub, full;
        longint sa, sb, s, lo, hi;
        exp_t e;
        e    = '0;
        full = 0;
        mask = (64'd1 << w) - 64'd1;
        ua   = {32'd0, a} & mask;
        ub   = {32'd0, b} & mask;
        hi   = (longint'(1) << (w - 1)) - 1;
        lo   = -(longint'(1) << (w - 1));
        sa   = (ua > longint'(hi)) ? longint'(ua) - (longint'(1) << w) : longint'(ua);
        sb   = (ub > longint'(hi)) ? longint'(ub) - (longint'(1) << w) : longint'(ub);
        case (op)
            ADD: begin full = ua + ub; s = sa + sb; e.carry = (full > mask); e.ovf = (s > hi) || (s < lo); end
            SUB: begin full = ua - ub; s = sa - sb; e.carry = (ua < ub);     e.ovf = (s > hi) || (s < lo); end
            XOR: full = ua ^ ub;
            BEQ: begin full = ua - ub; e.branch = (ua == ub); end
            OR:  full = ua | ub;
            AND: full = ua & ub;
            SLT: full = (sa < sb) ? 64'd1 : 64'd0;
            default: begin full = ua * ub; e.ovf = ((full >> w) != 0); end
        endcase
        e.r    = 32'(full & mask);
        e.zero = ((full & mask) == 0);
        return e;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return 32'h0000_0080;
            5: return 32'($urandom_range(0, 15));
            default: return $urandom();
        endcase
    endfunction

    // Called just after a rising edge; returns 1 time unit after the accept edge.
    task automatic issue_x(input int w, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input exp_t e);
        bit got = 1'b0;
        if (w == 32) begin
            b32.A = a; b32.B = b; b32.CTRL = op; b32.in_valid = 1'b1;
        end else begin
            b8.A = a[7:0]; b8.B = b[7:0]; b8.CTRL = op; b8.in_valid = 1'b1;
        end
        for (int n = 0; n < 300 && !got; n++) begin
            @(negedge clk);
            if ((w == 32) ? b32.in_ready : b8.in_ready) begin
                @(posedge clk);
                got = 1'b1;
                if (w == 32) q32.push_back(e);
                else         q8.push_back(e);
            end else begin
                @(posedge clk);
            end
        end
        check("issue accepted", 64'(got), 64'd1);
        #1;
        b32.in_valid = 1'b0;
        b8.in_valid  = 1'b0;
    endtask

    task automatic issue(input int w, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        issue_x(w, op, a, b, model(w, op, a, b));
    endtask

    task automatic drain();
        for (int n = 0; n < 300 && (q32.size() != 0 || q8.size() != 0); n++) @(posedge clk);
        #1;
        check("drain queues empty", 64'(q32.size() + q8.size()), 64'd0);
    endtask

    always @(negedge clk) begin : mon32
        exp_t e;
        if (reset && b32.out_valid && b32.out_ready) begin
            if (q32.size() == 0) begin
                total++; bad++;
                $display("FAIL w32 unexpected result R=%0h required=no result", b32.R);
            end else begin
                e = q32.pop_front();
                check("w32 result {R,zero,ovf,carry,branch}",
                      64'({b32.R, b32.zero, b32.ovf, b32.carry, b32.branch}), 64'(e));
            end
        end
    end

    always @(negedge clk) begin : mon8
        exp_t e;
        if (reset && b8.out_valid && b8.out_ready) begin
            if (q8.size() == 0) begin
                total++; bad++;
                $display("FAIL w8 unexpected result R=%0h required=no result", b8.R);
            end else begin
                e = q8.pop_front();
                check("w8 result {R,zero,ovf,carry,branch}",
                      64'({24'd0, b8.R, b8.zero, b8.ovf, b8.carry, b8.branch}), 64'(e));
            end
        end
    end

    always @(posedge clk) begin
        #1;
        rdy_rnd = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int viol;
        int stray;
        time t0;
        logic [2:0] sops [5];
        sops[0] = ADD; sops[1] = XOR; sops[2] = OR; sops[3] = AND; sops[4] = SUB;

        b32.in_valid = 1'b0; b32.A = '0; b32.B = '0; b32.CTRL = '0;
        b8.in_valid  = 1'b0; b8.A  = '0; b8.B  = '0; b8.CTRL  = '0;

        // Reset state
        #12;
        check("reset R", 64'(b32.R), 64'd0);
        check("reset zero", 64'(b32.zero), 64'd1);
        check("reset ovf/carry/branch", 64'({b32.ovf, b32.carry, b32.branch}), 64'd0);
        check("reset out_valid", 64'(b32.out_valid), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("in_ready after reset", 64'(b32.in_ready), 64'd1);

        // Directed arithmetic corner cases
        issue_x(32, ADD, 32'h7FFF_FFFF, 32'h1,        mk(32'h8000_0000, 0, 1, 0, 0));
        issue_x(32, ADD, 32'hFFFF_FFFF, 32'h1,        mk(32'h0,         1, 0, 1, 0));
        issue_x(32, SUB, 32'h3,         32'h5,        mk(32'hFFFF_FFFE, 0, 0, 1, 0));
        issue_x(32, SLT, 32'hFFFF_FFFF, 32'h1,        mk(32'h1,         0, 0, 0, 0));
        issue_x(32, BEQ, 32'h1234,      32'h1234,     mk(32'h0,         1, 0, 0, 1));

        // MUL latency, in_ready low while multiplying
        issue_x(32, MUL, 32'h0001_0000, 32'h0001_0001, mk(32'h0001_0000, 0, 1, 0, 0));
        lat = 0; viol = 0;
        while (!b32.out_valid && lat < 100) begin
            if (b32.in_ready) viol++;
            @(posedge clk);
            #1;
            lat++;
        end
        check("mul latency cycles", 64'(lat), 64'd32);
        check("in_ready high during mul", 64'(viol), 64'd0);
        issue_x(32, MUL, 32'd7, 32'd6, mk(32'd42, 0, 0, 0, 0));
        drain();

        // Backpressure: result held, then pop + accept on one edge
        rdy32_m = 1'b0;
        issue_x(32, ADD, 32'd100, 32'd23, mk(32'd123, 0, 0, 0, 0));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp R stable", 64'(b32.R), 64'd123);
            check("bp out_valid held", 64'(b32.out_valid), 64'd1);
            check("bp in_ready low", 64'(b32.in_ready), 64'd0);
            @(posedge clk);
        end
        #1;
        rdy32_m = 1'b1;
        issue_x(32, XOR, 32'hF0F0_0000, 32'h0FF0_1234, mk(32'hFF00_1234, 0, 0, 0, 0));
        check("bp next result", 64'({b32.out_valid, b32.R}), 64'({1'b1, 32'hFF00_1234}));
        drain();

        // Reset in the middle of a MUL
        issue(32, MUL, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (4) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        q32.delete();
        q8.delete();
        check("mid-mul reset out_valid", 64'(b32.out_valid), 64'd0);
        check("mid-mul reset R", 64'(b32.R), 64'd0);
        check("mid-mul reset zero", 64'(b32.zero), 64'd1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("in_ready after mid-mul reset", 64'(b32.in_ready), 64'd1);
        stray = 0;
        for (int i = 0; i < 40; i++) begin
            if (b32.out_valid) stray++;
            @(posedge clk);
            #1;
        end
        check("no stray result after reset", 64'(stray), 64'd0);

        // Streaming: 8 single-cycle ops, one per cycle
        t0 = $time;
        for (int i = 0; i < 8; i++) issue(32, sops[$urandom_range(0, 4)], $urandom(), $urandom());
        check("stream accept cycles", 64'(($time - t0) / 10), 64'd8);
        drain();

        // Random ops with random output backpressure, both widths
        bp_en = 1'b1;
        for (int i = 0; i < 80; i++)  issue(32, 3'($urandom_range(0, 7)), pick(), pick());
        for (int i = 0; i < 200; i++) issue(8,  3'($urandom_range(0, 7)), pick(), pick());
        bp_en = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
